// File: rtl/bitwise_logic_mc.sv
// Multicycle bitwise logic unit: one of eight ops, SLICE bits per cycle, start/done handshake.
// Latency N=WIDTH/SLICE cycles from accept to done; start is only sampled in IDLE or DONE.
module bitwise_logic_mc #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("bitwise_logic_mc: WIDTH must be an integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;

  logic [WIDTH-1:0] f_full;
  logic [WIDTH-1:0] acc_d;
  logic             last_slice;

  // Full-width function of the latched operands; only the active slice is committed.
  always_comb begin
    f_full = '0;
    case (op_q)
      3'b000:  f_full = a_q & b_q;
      3'b001:  f_full = a_q | b_q;
      3'b010:  f_full = a_q ^ b_q;
      3'b011:  f_full = ~(a_q | b_q);
      3'b100:  f_full = ~(a_q & b_q);
      3'b101:  f_full = ~(a_q ^ b_q);
      3'b110:  f_full = a_q;
      default: f_full = a_q & ~b_q;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i / SLICE) == int'(cnt_q)) acc_d[i] = f_full[i];
    end
  end

  assign last_slice = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (last_slice) begin
            // acc_d already holds the final slice, so result never shows a partial word.
            res_q   <= acc_d;
            zero_q  <= (acc_d == '0);
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bitwise_logic_mc.sv
// Bench for bitwise_logic_mc: default 32/8 instance plus 64/16, 8/8 and 16/1 instances
// sharing the handshake inputs, checked against a whole-word reference model.
module tb_bitwise_logic_mc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a64;
  logic [63:0] b64;

  logic        busy0, done0, zero0;
  logic [31:0] res0;
  logic        busy1, done1, zero1;
  logic [63:0] res1;
  logic        busy2, done2, zero2;
  logic [7:0]  res2;
  logic        busy3, done3, zero3;
  logic [15:0] res3;

  int vectors;
  int miscompares;

  bitwise_logic_mc #(.WIDTH(32), .SLICE(8)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a64[31:0]), .b(b64[31:0]),
    .busy(busy0), .done(done0), .result(res0), .zero(zero0));
  bitwise_logic_mc #(.WIDTH(64), .SLICE(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a64), .b(b64),
    .busy(busy1), .done(done1), .result(res1), .zero(zero1));
  bitwise_logic_mc #(.WIDTH(8), .SLICE(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a64[7:0]), .b(b64[7:0]),
    .busy(busy2), .done(done2), .result(res2), .zero(zero2));
  bitwise_logic_mc #(.WIDTH(16), .SLICE(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a64[15:0]), .b(b64[15:0]),
    .busy(busy3), .done(done3), .result(res3), .zero(zero3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] x,
                                         input logic [63:0] y, input int w);
    logic [63:0] r;
    logic [63:0] m;
    case (f)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x | y);
      3'd4: r = ~(x & y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x;
      default: r = x & ~y;
    endcase
    m = '1;
    if (w < 64) m = (64'd1 << w) - 64'd1;
    return r & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a64 = {$urandom, $urandom};
    b64 = {$urandom, $urandom};
    op  = 3'($urandom_range(0, 7));
  endtask

  // One operation on the 32/8 instance; inputs scrambled right after accept.
  task automatic run0(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                      input string tag);
    int lat;
    int bcnt;
    logic [31:0] exp;
    exp = 32'(model(f, {32'd0, x}, {32'd0, y}, 32));
    op = f; a64 = {32'd0, x}; b64 = {32'd0, y}; start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    lat = 0; bcnt = 0;
    while (!done0 && lat < 20) begin
      if (busy0) bcnt++;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_busycyc"}, 64'(bcnt), 64'd4);
    chk({tag, "_busy_at_done"}, {63'd0, busy0}, 64'd0);
    chk({tag, "_res"}, {32'd0, res0}, {32'd0, exp});
    chk({tag, "_zero"}, {63'd0, zero0}, {63'd0, (exp == 32'd0)});
    tick();
    chk({tag, "_done_pulse"}, {63'd0, done0}, 64'd0);
    chk({tag, "_res_hold"}, {32'd0, res0}, {32'd0, exp});
  endtask

  task automatic sweep(input int iter);
    logic [63:0] sa, sb;
    logic [2:0]  sop;
    int l0, l1, l2, l3;
    logic [63:0] r0, r1, r2, r3;
    logic overlap;
    scramble();
    sa = a64; sb = b64; sop = op;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    l0 = -1; l1 = -1; l2 = -1; l3 = -1;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;
    overlap = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      if ((busy0 && done0) || (busy1 && done1) || (busy2 && done2) || (busy3 && done3))
        overlap = 1'b1;
      if (done0 && l0 < 0) begin l0 = t; r0 = {32'd0, res0}; end
      if (done1 && l1 < 0) begin l1 = t; r1 = res1; end
      if (done2 && l2 < 0) begin l2 = t; r2 = {56'd0, res2}; end
      if (done3 && l3 < 0) begin l3 = t; r3 = {48'd0, res3}; end
      if (t < 40) tick();
    end
    chk($sformatf("sw%0d_lat_32_8", iter),  64'(l0), 64'd4);
    chk($sformatf("sw%0d_lat_64_16", iter), 64'(l1), 64'd4);
    chk($sformatf("sw%0d_lat_8_8", iter),   64'(l2), 64'd1);
    chk($sformatf("sw%0d_lat_16_1", iter),  64'(l3), 64'd16);
    chk($sformatf("sw%0d_res_32_8", iter),  r0, model(sop, sa, sb, 32));
    chk($sformatf("sw%0d_res_64_16", iter), r1, model(sop, sa, sb, 64));
    chk($sformatf("sw%0d_res_8_8", iter),   r2, model(sop, sa, sb, 8));
    chk($sformatf("sw%0d_res_16_1", iter),  r3, model(sop, sa, sb, 16));
    chk($sformatf("sw%0d_zero_16_1", iter), {63'd0, zero3},
        {63'd0, (model(sop, sa, sb, 16) == 64'd0)});
    chk($sformatf("sw%0d_busy_done_overlap", iter), {63'd0, overlap}, 64'd0);
  endtask

  initial begin
    int gap;
    int dcnt;
    logic [31:0] v2a, v2b;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1; start = 1'b0; op = '0; a64 = '0; b64 = '0;

    // Asynchronous reset asserted between edges, observed before any edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", {32'd0, res0}, 64'd0);
    chk("rst_zero", {63'd0, zero0}, 64'd1);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    run0(3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, "or");
    chk("or_literal", {32'd0, res0}, 64'h0000_0000_FFFF_00FF);

    for (int k = 0; k < 8; k++)
      run0(3'(k), 32'hAAAA_5555, 32'hFFFF_0000, $sformatf("op%0d", k));

    run0(3'b010, 32'h1234_5678, 32'h1234_5678, "xor_eq");
    chk("xor_eq_zero", {63'd0, zero0}, 64'd1);

    // Back-to-back with start held high; inputs churn during RUN.
    op = 3'b111; a64 = {32'd0, 32'hDEAD_BEEF}; b64 = {32'd0, 32'h0F0F_0F0F}; start = 1'b1;
    tick();
    dcnt = 0;
    while (!done0 && dcnt < 20) begin
      scramble();
      tick();
      dcnt++;
    end
    chk("b2b_first_lat", 64'(dcnt), 64'd4);
    chk("b2b_first_res", {32'd0, res0}, model(3'b111, 64'hDEAD_BEEF, 64'h0F0F_0F0F, 32));
    v2a = $urandom; v2b = $urandom;
    op = 3'b101; a64 = {32'd0, v2a}; b64 = {32'd0, v2b};
    tick();
    gap = 1;
    while (!done0 && gap < 20) begin
      scramble();
      tick();
      gap++;
    end
    chk("b2b_gap", 64'(gap), 64'd5);
    chk("b2b_second_res", {32'd0, res0}, model(3'b101, {32'd0, v2a}, {32'd0, v2b}, 32));
    start = 1'b0;
    tick();
    tick();

    // Reset during slice 2 of a NAND.
    op = 3'b100; a64 = {32'd0, 32'h1357_9BDF}; b64 = {32'd0, 32'h0246_8ACE}; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", {32'd0, res0}, 64'd0);
    chk("midrst_zero", {63'd0, zero0}, 64'd1);
    chk("midrst_busy", {63'd0, busy0}, 64'd0);
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int t = 0; t < 8; t++) begin
      if (done0) dcnt++;
      tick();
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    chk("midrst_result_after", {32'd0, res0}, 64'd0);
    run0(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "post_rst_and");

    // Let the 16-cycle instance drain before the shared-start sweep.
    for (int t = 0; t < 20; t++) tick();
    for (int i = 0; i < 6; i++) sweep(i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
